// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: pipeline stage codes,
// forwarding-select encodings and default widths.
package hazard_stall_ctrl_pkg;

    localparam int TW_DEFAULT = 2;

    typedef enum logic [1:0] {
        STG_D = 2'd0,
        STG_E = 2'd1,
        STG_M = 2'd2,
        STG_W = 2'd3
    } stage_e;

    // A forwarding select names the stage the operand is taken from; D means the regfile.
    localparam logic [1:0] FWD_RF = STG_D;
    localparam logic [1:0] FWD_E  = STG_E;
    localparam logic [1:0] FWD_M  = STG_M;
    localparam logic [1:0] FWD_W  = STG_W;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads the unit latency on a start and counts
// down to idle; busy while nonzero.
module md_busy_cnt
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A start while busy simply reloads; the unit restarts with the new operation.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall and forwarding control for a D/E/M/W pipeline, with a private shadow
// of each stage's destination register and Tnew, plus mult/div occupancy.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int RW          = 5,
    parameter int TW          = TW_DEFAULT,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [RW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          md_start,
    input  logic          md_is_div,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic          fwd_m_rt,
    output logic          md_busy
);

    logic [RW-1:0] dst_e_q, dst_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [TW-1:0] tnew_e_q, tnew_e_d;
    logic [RW-1:0] dst_m_q, dst_m_d, rt_m_q, rt_m_d;
    logic [TW-1:0] tnew_m_q, tnew_m_d;
    logic [RW-1:0] dst_w_q, dst_w_d;
    logic [TW-1:0] tnew_w_q, tnew_w_d;

    logic rs_haz, rt_haz, md_haz;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // First matching stage decides; a match that is not yet ready blocks older stages.
    function automatic logic [1:0] fwd_pick(
        input logic [RW-1:0] addr,
        input logic          use_e,
        input logic [RW-1:0] de,
        input logic [TW-1:0] te,
        input logic [RW-1:0] dm,
        input logic [TW-1:0] tm,
        input logic [RW-1:0] dw,
        input logic [TW-1:0] t_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (addr != '0) begin
            if (use_e && de == addr) begin
                if (te == '0) sel = FWD_E;
            end else if (dm == addr) begin
                if (tm == '0) sel = FWD_M;
            end else if (dw == addr && t_w == '0) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .is_div_i (md_is_div),
        .busy_o   (md_busy)
    );

    // Only E and M can still be producing a value the D instruction needs; W is always ready.
    always_comb begin
        rs_haz = (d_rs != '0) &&
                 ((dst_e_q == d_rs && tnew_e_q > d_tuse_rs) ||
                  (dst_m_q == d_rs && tnew_m_q > d_tuse_rs));
        rt_haz = (d_rt != '0) &&
                 ((dst_e_q == d_rt && tnew_e_q > d_tuse_rt) ||
                  (dst_m_q == d_rt && tnew_m_q > d_tuse_rt));
        md_haz = d_is_md && (md_start || md_busy);
        stall  = rs_haz || rt_haz || md_haz;
    end

    // NOTE: every next-state signal gets a value on every path so no latch is inferred.
    always_comb begin
        if (stall) begin
            dst_e_d  = '0;
            tnew_e_d = '0;
            rs_e_d   = '0;
            rt_e_d   = '0;
        end else begin
            dst_e_d  = d_dst;
            tnew_e_d = d_tnew;
            rs_e_d   = d_rs;
            rt_e_d   = d_rt;
        end
        dst_m_d  = dst_e_q;
        tnew_m_d = dec_sat(tnew_e_q);
        rt_m_d   = rt_e_q;
        dst_w_d  = dst_m_q;
        tnew_w_d = dec_sat(tnew_m_q);
    end

    // NOTE: non-blocking updates let every stage sample the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            dst_e_q  <= '0;
            tnew_e_q <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            dst_m_q  <= '0;
            tnew_m_q <= '0;
            rt_m_q   <= '0;
            dst_w_q  <= '0;
            tnew_w_q <= '0;
        end else begin
            dst_e_q  <= dst_e_d;
            tnew_e_q <= tnew_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            dst_m_q  <= dst_m_d;
            tnew_m_q <= tnew_m_d;
            rt_m_q   <= rt_m_d;
            dst_w_q  <= dst_w_d;
            tnew_w_q <= tnew_w_d;
        end
    end

    always_comb begin
        fwd_d_rs = fwd_pick(d_rs, 1'b1, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q, dst_w_q, tnew_w_q);
        fwd_d_rt = fwd_pick(d_rt, 1'b1, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q, dst_w_q, tnew_w_q);
        fwd_e_rs = fwd_pick(rs_e_q, 1'b0, '0, '0, dst_m_q, tnew_m_q, dst_w_q, tnew_w_q);
        fwd_e_rt = fwd_pick(rt_e_q, 1'b0, '0, '0, dst_m_q, tnew_m_q, dst_w_q, tnew_w_q);
        fwd_m_rt = (fwd_pick(rt_m_q, 1'b0, '0, '0, '0, '0, dst_w_q, tnew_w_q) == FWD_W);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: inputs change on the falling edge,
// outputs are compared 1 ns later against hand-derived values.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_is_md, md_start, md_is_div;
    logic       stall, fwd_m_rt, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int n_cmp;
    int n_err;

    hazard_stall_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_dst     (d_dst),
        .d_tnew    (d_tnew),
        .d_is_md   (d_is_md),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .fwd_m_rt  (fwd_m_rt),
        .md_busy   (md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        d_rs = '0; d_rt = '0; d_dst = '0;
        d_tuse_rs = '0; d_tuse_rt = '0; d_tnew = '0;
        d_is_md = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    endtask

    task automatic flush(input int n);
        idle();
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_d_rs !== 2'd0) begin n_err++; $display("FAIL reset_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        n_cmp++; if (fwd_d_rt !== 2'd0) begin n_err++; $display("FAIL reset_fwd_d_rt: got %0d want 0", fwd_d_rt); end
        n_cmp++; if (fwd_e_rs !== 2'd0) begin n_err++; $display("FAIL reset_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        n_cmp++; if (fwd_e_rt !== 2'd0) begin n_err++; $display("FAIL reset_fwd_e_rt: got %0d want 0", fwd_e_rt); end
        n_cmp++; if (fwd_m_rt !== 1'b0) begin n_err++; $display("FAIL reset_fwd_m_rt: got %b want 0", fwd_m_rt); end
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        md_start = 1'b1; d_is_md = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_live_md_stall: got %b want 1", stall); end
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored: got %b want 0", md_busy); end
    endtask

    task automatic test_load_use();
        flush(3);
        d_dst = 5'd1; d_tnew = 2'd2;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_pre_stall: got %b want 0", stall); end
        @(negedge clk);
        idle();
        d_rs = 5'd1; d_tuse_rs = 2'd1; d_rt = 5'd4; d_tuse_rt = 2'd1; d_dst = 5'd5; d_tnew = 2'd1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall); end
        @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", stall); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (fwd_e_rs !== 2'd3) begin n_err++; $display("FAIL lu_fwd_e_rs: got %0d want 3", fwd_e_rs); end
        n_cmp++; if (fwd_e_rt !== 2'd0) begin n_err++; $display("FAIL lu_fwd_e_rt: got %0d want 0", fwd_e_rt); end
    endtask

    task automatic test_branch();
        flush(3);
        d_dst = 5'd2; d_tnew = 2'd1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL br_pre_stall: got %b want 0", stall); end
        @(negedge clk);
        idle();
        d_rs = 5'd2; d_tuse_rs = 2'd0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL br_stall: got %b want 1", stall); end
        @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL br_release: got %b want 0", stall); end
        n_cmp++; if (fwd_d_rs !== 2'd2) begin n_err++; $display("FAIL br_fwd_d_rs: got %0d want 2", fwd_d_rs); end
    endtask

    task automatic test_zero_reg();
        flush(3);
        for (int i = 0; i < 3; i++) begin
            idle();
            d_dst = 5'd0; d_tnew = 2'd2;
            @(negedge clk);
        end
        idle();
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zr_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_d_rs !== 2'd0) begin n_err++; $display("FAIL zr_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        n_cmp++; if (fwd_d_rt !== 2'd0) begin n_err++; $display("FAIL zr_fwd_d_rt: got %0d want 0", fwd_d_rt); end
        n_cmp++; if (fwd_e_rs !== 2'd0) begin n_err++; $display("FAIL zr_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        n_cmp++; if (fwd_e_rt !== 2'd0) begin n_err++; $display("FAIL zr_fwd_e_rt: got %0d want 0", fwd_e_rt); end
        n_cmp++; if (fwd_m_rt !== 1'b0) begin n_err++; $display("FAIL zr_fwd_m_rt: got %b want 0", fwd_m_rt); end
    endtask

    task automatic test_store_fwd();
        flush(3);
        d_dst = 5'd6; d_tnew = 2'd2;
        @(negedge clk);
        idle();
        d_rt = 5'd6; d_tuse_rt = 2'd2;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_no_stall: got %b want 0", stall); end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        n_cmp++; if (fwd_m_rt !== 1'b1) begin n_err++; $display("FAIL st_fwd_m_rt: got %b want 1", fwd_m_rt); end
        n_cmp++; if (fwd_e_rt !== 2'd0) begin n_err++; $display("FAIL st_fwd_e_rt: got %0d want 0", fwd_e_rt); end
    endtask

    task automatic test_mult_busy();
        flush(12);
        md_start = 1'b1; md_is_div = 1'b0; d_is_md = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mul_start_stall: got %b want 1", stall); end
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mul_start_busy: got %b want 0", md_busy); end
        for (int i = 1; i <= 6; i++) begin
            logic exp_busy;
            @(negedge clk);
            idle();
            d_is_md = 1'b1;
            exp_busy = (i <= 5);
            #1;
            n_cmp++; if (stall !== exp_busy) begin n_err++; $display("FAIL mul_stall_c%0d: got %b want %b", i, stall, exp_busy); end
            n_cmp++; if (md_busy !== exp_busy) begin n_err++; $display("FAIL mul_busy_c%0d: got %b want %b", i, md_busy, exp_busy); end
        end
    endtask

    task automatic test_md_reload();
        flush(12);
        md_start = 1'b1; md_is_div = 1'b0;
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        md_start = 1'b1; md_is_div = 1'b1;
        #1;
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL rl_busy_at_reload: got %b want 1", md_busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rl_no_md_user: got %b want 0", stall); end
        for (int i = 0; i <= 10; i++) begin
            logic exp_busy;
            @(negedge clk);
            idle();
            exp_busy = (i < 10);
            #1;
            n_cmp++; if (md_busy !== exp_busy) begin n_err++; $display("FAIL rl_busy_c%0d: got %b want %b", i, md_busy, exp_busy); end
        end
    endtask

    task automatic test_reset_mid_div();
        flush(12);
        md_start = 1'b1; md_is_div = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rd_start_stall: got %b want 0", stall); end
        @(negedge clk);
        idle();
        @(negedge clk);
        d_dst = 5'd7; d_tnew = 2'd2;
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_before_edge: got %b want 1", md_busy); end
        @(negedge clk);
        reset = 1'b0;
        d_rs = 5'd7; d_rt = 5'd7; d_is_md = 1'b1;
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b want 0", md_busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rd_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_d_rs !== 2'd0) begin n_err++; $display("FAIL rd_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        n_cmp++; if (fwd_d_rt !== 2'd0) begin n_err++; $display("FAIL rd_fwd_d_rt: got %0d want 0", fwd_d_rt); end
        n_cmp++; if (fwd_e_rs !== 2'd0) begin n_err++; $display("FAIL rd_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        n_cmp++; if (fwd_m_rt !== 1'b0) begin n_err++; $display("FAIL rd_fwd_m_rt: got %b want 0", fwd_m_rt); end
    endtask

    task automatic test_fwd_priority();
        flush(3);
        d_dst = 5'd3; d_tnew = 2'd0;
        @(negedge clk);
        @(negedge clk);
        idle();
        d_rs = 5'd3; d_rt = 5'd3;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL pr_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_d_rs !== 2'd1) begin n_err++; $display("FAIL pr_e_wins_rs: got %0d want 1", fwd_d_rs); end
        n_cmp++; if (fwd_d_rt !== 2'd1) begin n_err++; $display("FAIL pr_e_wins_rt: got %0d want 1", fwd_d_rt); end
        @(negedge clk);
        idle();
        d_rs = 5'd3;
        #1;
        n_cmp++; if (fwd_d_rs !== 2'd2) begin n_err++; $display("FAIL pr_m_wins_d: got %0d want 2", fwd_d_rs); end
        n_cmp++; if (fwd_e_rs !== 2'd2) begin n_err++; $display("FAIL pr_m_wins_e_rs: got %0d want 2", fwd_e_rs); end
        n_cmp++; if (fwd_e_rt !== 2'd2) begin n_err++; $display("FAIL pr_m_wins_e_rt: got %0d want 2", fwd_e_rt); end
        @(negedge clk);
        #1;
        n_cmp++; if (fwd_d_rs !== 2'd3) begin n_err++; $display("FAIL pr_w_only_d: got %0d want 3", fwd_d_rs); end
        n_cmp++; if (fwd_e_rs !== 2'd3) begin n_err++; $display("FAIL pr_w_only_e: got %0d want 3", fwd_e_rs); end
        n_cmp++; if (fwd_m_rt !== 1'b1) begin n_err++; $display("FAIL pr_w_to_m: got %b want 1", fwd_m_rt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_store_fwd();
        test_mult_busy();
        test_md_reload();
        test_reset_mid_div();
        test_fwd_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
